leaf_tx_sched: RTL

Transmit scheduler and receive capture for one BFT leaf port. Shares the leaf's single injection port among `num_req` local requesters using round-robin arbitration. Assembles each granted request into a network packet `{valid, dest, payload}`. Holds and re-presents the packet whenever the network asserts `resend`. Registers packets delivered to the leaf and keeps traffic statistics. Sits between local producers/consumers and the leaf's `pe_interface`/`interface_pe`/`resend` connection to `gen_nw`.

---
 rtl/leaf_tx_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/leaf_tx_sched.sv
// leaf_tx_sched
// Transmit scheduler and receive capture for one BFT leaf port.
// Several local requesters share the leaf's single injection port. A
// round-robin arbiter picks one of them, its request is assembled into a
// {valid, dest, payload} packet, and that packet is held and re-presented
// for as long as the network keeps asserting resend. Packets delivered by
// the network are registered, and traffic statistics are kept.
//
// Ports
//   clk          in   clock, everything on the rising edge
//   reset        in   synchronous active-low reset
//   en           in   high allows new grants (an in-flight packet is never dropped)
//   req_valid    in   [num_req]           requester i has a packet pending
//   req_dest     in   [num_req*L]         destination leaf, slice i at [i*L +: L]
//   req_payload  in   [num_req*payload_sz] payload, slice i at [i*payload_sz +: payload_sz]
//   req_ready    out  [num_req]           one-hot or zero, combinational accept
//   pe_interface out  [p_sz]              registered packet to the network
//   interface_pe in   [p_sz]              packet from the network
//   resend       in   network rejected the current pe_interface packet
//   rx_valid     out  registered: a packet arrived
//   rx_data      out  [p_sz-1]            registered dest+payload of the last arrival
//   tx_count     out  [32]                accepted packets (wraps)
//   rx_count     out  [32]                received packets (wraps)
//   retry_count  out  [32]                rejected presentations (wraps)
//   busy         out  transmit slot is occupied
module leaf_tx_sched #(
    parameter int num_leaves = 256,
    parameter int payload_sz = 43,
    parameter int p_sz       = 52,
    parameter int num_req    = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   en,
    input  logic [num_req-1:0]                     req_valid,
    input  logic [num_req*$clog2(num_leaves)-1:0]  req_dest,
    input  logic [num_req*payload_sz-1:0]          req_payload,
    output logic [num_req-1:0]                     req_ready,
    output logic [p_sz-1:0]                        pe_interface,
    input  logic [p_sz-1:0]                        interface_pe,
    input  logic                                   resend,
    output logic                                   rx_valid,
    output logic [p_sz-2:0]                        rx_data,
    output logic [31:0]                            tx_count,
    output logic [31:0]                            rx_count,
    output logic [31:0]                            retry_count,
    output logic                                   busy
);

    localparam int L = $clog2(num_leaves);
    localparam int R = $clog2(num_req);

    logic [p_sz-1:0] pe_r;
    logic [R-1:0]    last_r;
    logic [R-1:0]    winner_s;
    logic            found_s;
    logic            valid_s;
    logic            load_s;
    logic            rx_valid_r;
    logic [p_sz-2:0] rx_data_r;
    logic [31:0]     tx_count_r;
    logic [31:0]     rx_count_r;
    logic [31:0]     retry_count_r;

    assign valid_s = pe_r[p_sz-1];

    // The slot can take a new packet when empty or when the current one is being accepted.
    // reset is folded in so req_ready stays low throughout reset.
    assign load_s = reset & en & (|req_valid) & (~valid_s | ~resend);

    // Round-robin search: first pending requester after the previous winner.
    always_comb begin
        int idx_v;
        winner_s = last_r;
        found_s  = 1'b0;
        idx_v    = 0;
        for (int k = 1; k <= num_req; k++) begin
            idx_v = (int'(last_r) + k) % num_req;
            if (!found_s && req_valid[idx_v]) begin
                winner_s = R'(idx_v);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Accept strobe goes only to the winner, and only when the slot loads.
    always_comb begin
        req_ready = '0;
        if (load_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Transmit slot, arbitration pointer and statistics.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pe_r          <= '0;
            last_r        <= R'(num_req - 1);
            tx_count_r    <= 32'd0;
            retry_count_r <= 32'd0;
        end else begin
            if (load_s) begin
                pe_r   <= {1'b1,
                           req_dest[int'(winner_s)*L +: L],
                           req_payload[int'(winner_s)*payload_sz +: payload_sz]};
                last_r <= winner_s;
            end else if (valid_s && !resend) begin
                pe_r   <= '0;
                last_r <= last_r;
            end else begin
                // HOLD re-presents the packet unchanged; EMPTY stays zero.
                pe_r   <= pe_r;
                last_r <= last_r;
            end

            if (valid_s && !resend) begin
                tx_count_r <= tx_count_r + 32'd1;
            end else begin
                tx_count_r <= tx_count_r;
            end

            if (valid_s && resend) begin
                retry_count_r <= retry_count_r + 32'd1;
            end else begin
                retry_count_r <= retry_count_r;
            end
        end
    end

    // Receive capture; there is no backpressure toward the network.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_valid_r <= 1'b0;
            rx_data_r  <= '0;
            rx_count_r <= 32'd0;
        end else begin
            rx_valid_r <= interface_pe[p_sz-1];
            if (interface_pe[p_sz-1]) begin
                rx_data_r  <= interface_pe[p_sz-2:0];
                rx_count_r <= rx_count_r + 32'd1;
            end else begin
                rx_data_r  <= rx_data_r;
                rx_count_r <= rx_count_r;
            end
        end
    end

    assign pe_interface = pe_r;
    assign busy         = pe_r[p_sz-1];
    assign rx_valid     = rx_valid_r;
    assign rx_data      = rx_data_r;
    assign tx_count     = tx_count_r;
    assign rx_count     = rx_count_r;
    assign retry_count  = retry_count_r;

endmodule
